// File: rtl/operand_entry_if.sv
// operand_entry_if: user-facing operand entry bus.
// The slave side is the operand_entry block. The master side is whatever
// drives the raw button/switches and consumes the captured operand pair.
interface operand_entry_if;
  logic       KEY_ENTER;  // raw pushbutton, active-low
  logic [3:0] SW;         // raw operand switches
  logic [7:0] OPS;        // captured operands {B, A}
  logic       VALID;      // both operands captured
  logic [1:0] LEDR;       // state code

  modport master (
    output KEY_ENTER,
    output SW,
    input  OPS,
    input  VALID,
    input  LEDR
  );

  modport slave (
    input  KEY_ENTER,
    input  SW,
    output OPS,
    output VALID,
    output LEDR
  );
endinterface

// File: rtl/operand_entry.sv
// operand_entry: debounced two-operand capture stage for the 4-bit adder.
// A raw active-low pushbutton is synchronized and debounced. Each debounced
// press steps an FSM: WAIT_A captures A, WAIT_B captures B, and DONE clears
// the pair. The pair is presented as a stable {B, A} bus with a VALID flag
// and a state code on the LEDs.
// Optional feature macro: ENTRY_TIMEOUT_EN. When it is defined, an idle
// WAIT_B (no debounced activity for TIMEOUT_CYCLES cycles) abandons the
// entry and returns to WAIT_A.
module operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  operand_entry_if.slave bus
);

  // Counter width: the minimum number of bits that holds DEBOUNCE_CYCLES-1.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 32'd2) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_WAIT_A = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Synchronizer stages
  logic            key_meta_q;
  logic            key_sync_q;
  logic [3:0]      sw_meta_q;
  logic [3:0]      sw_sync_q;

  // Debounce state
  logic            deb_q;
  logic            deb_d;
  logic            prev_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            press_s;
  logic            deb_change_s;

  // FSM and registered outputs
  state_e          state_q;
  state_e          state_d;
  logic [7:0]      ops_q;
  logic [7:0]      ops_d;
  logic            valid_q;
  logic            valid_d;
  logic [1:0]      ledr_q;
  logic [1:0]      ledr_d;
  logic            timeout_s;

  // Two-flop synchronizers for the asynchronous button and switches; reset to released.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      sw_meta_q  <= 4'h0;
      sw_sync_q  <= 4'h0;
    end else begin
      key_meta_q <= bus.KEY_ENTER;
      key_sync_q <= key_meta_q;
      sw_meta_q  <= bus.SW;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    if (key_sync_q != deb_q) begin
      if (db_cnt_q >= DB_MAX) begin
        // Held long enough: take the new level and restart the count.
        deb_d    = key_sync_q;
        db_cnt_d = {DB_W{1'b0}};
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      // Any matching cycle discards a partial count, so short glitches vanish.
      db_cnt_d = {DB_W{1'b0}};
    end
  end

  // Debounced level, its one-cycle-delayed copy, and the stability counter.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb_q    <= 1'b1;
      prev_q   <= 1'b1;
      db_cnt_q <= {DB_W{1'b0}};
    end else begin
      deb_q    <= deb_d;
      prev_q   <= deb_q;
      db_cnt_q <= db_cnt_d;
    end
  end

  // A press is a debounced 1->0 edge; releases and held levels produce nothing.
  assign press_s      = prev_q & ~deb_q;
  assign deb_change_s = (deb_d != deb_q);

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 32'd1);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;

  // Idle counter: runs only in WAIT_B, restarts on any debounced level change, saturates.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_s = 1'b0;
    if (state_q != ST_WAIT_B) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (deb_change_s) begin
      to_cnt_d = {TO_W{1'b0}};
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    timeout_s = (state_q == ST_WAIT_B) && (to_cnt_q == TO_MAX);
  end

  // Idle counter register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt_q <= {TO_W{1'b0}};
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the timeout, WAIT_B waits for B indefinitely.
  logic unused_timeout_s;
  assign timeout_s        = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 32'd0) | deb_change_s;
`endif

  // Entry FSM next state plus next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    case (state_q)
      ST_WAIT_A: begin
        if (press_s) begin
          ops_d   = {4'h0, sw_sync_q};
          state_d = ST_WAIT_B;
        end else begin
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        // A press coinciding with the timeout still captures B.
        if (press_s) begin
          ops_d   = {sw_sync_q, ops_q[3:0]};
          state_d = ST_DONE;
        end else if (timeout_s) begin
          ops_d   = 8'h00;
          state_d = ST_WAIT_A;
        end else begin
          state_d = ST_WAIT_B;
        end
      end
      ST_DONE: begin
        // A press here only clears; it never captures.
        if (press_s) begin
          ops_d   = 8'h00;
          state_d = ST_WAIT_A;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        ops_d   = 8'h00;
        state_d = ST_WAIT_A;
      end
    endcase

    valid_d = (state_d == ST_DONE);

    case (state_d)
      ST_WAIT_A: ledr_d = 2'b00;
      ST_WAIT_B: ledr_d = 2'b01;
      ST_DONE:   ledr_d = 2'b10;
      default:   ledr_d = 2'b00;
    endcase
  end

  // FSM state and registered outputs; reset clears the pair immediately.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_WAIT_A;
      ops_q   <= 8'h00;
      valid_q <= 1'b0;
      ledr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      valid_q <= valid_d;
      ledr_q  <= ledr_d;
    end
  end

  assign bus.OPS   = ops_q;
  assign bus.VALID = valid_q;
  assign bus.LEDR  = ledr_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed plus randomized bench for operand_entry.
// A reference model tracks the key/switch sample history. It decides a
// debounced edge from "the synchronized key has differed from the accepted
// level for the last N samples", and it applies the entry rules one clock
// after each debounced press.
module tb_operand_entry;

  localparam int DB = 4;
  localparam int TO = 20;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  operand_entry_if bus ();

  operand_entry #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_state;   // 0 WAIT_A, 1 WAIT_B, 2 DONE
  logic [7:0] m_ops;
  logic       m_deb;
  logic       m_pulse;
  int         m_idle;
  logic       kh[$];     // key value sampled at each clock edge
  logic [3:0] swh[$];    // switch value sampled at each clock edge

  function automatic void m_reset();
    m_state = 0;
    m_ops   = 8'h00;
    m_deb   = 1'b1;
    m_pulse = 1'b0;
    m_idle  = 0;
    kh.delete();
    swh.delete();
    for (int i = 0; i < DB + 2; i++) begin
      kh.push_back(1'b1);
      swh.push_back(4'h0);
    end
  endfunction

  // Advance the model by one clock edge that sampled key k and switches s.
  function automatic void m_edge(input logic k, input logic [3:0] s);
    int         n;
    logic       flip;
    logic       press;
    logic       tmo;
    logic [3:0] swc;
    n     = kh.size();
    press = m_pulse;
    // The synchronized value seen at this edge is the one sampled two edges ago.
    flip = 1'b1;
    for (int i = n - 1 - DB; i <= n - 2; i++) begin
      if (kh[i] == m_deb) flip = 1'b0;
    end
    swc = swh[n - 2];
`ifdef ENTRY_TIMEOUT_EN
    tmo = (m_state == 1) && (m_idle == TO - 1);
`else
    tmo = 1'b0;
`endif
    if (m_state != 1 || flip) m_idle = 0;
    else if (m_idle < TO - 1) m_idle = m_idle + 1;
    if (press) begin
      if (m_state == 0) begin
        m_ops   = {4'h0, swc};
        m_state = 1;
      end else if (m_state == 1) begin
        m_ops[7:4] = swc;
        m_state    = 2;
      end else begin
        m_ops   = 8'h00;
        m_state = 0;
      end
    end else if (tmo) begin
      m_ops   = 8'h00;
      m_state = 0;
    end
    m_pulse = flip && m_deb;
    m_deb   = m_deb ^ flip;
    kh.push_back(k);
    swh.push_back(s);
    void'(kh.pop_front());
    void'(swh.pop_front());
  endfunction

  // ---------------- checking ----------------
  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the falling edge.
  task automatic step(input logic k, input logic [3:0] s);
    bus.KEY_ENTER = k;
    bus.SW        = s;
    @(posedge clk);
    m_edge(k, s);
    @(negedge clk);
    chk_val("ops",   {24'h0, bus.OPS},   {24'h0, m_ops});
    chk_val("valid", {31'h0, bus.VALID}, {31'h0, (m_state == 2)});
    chk_val("ledr",  {30'h0, bus.LEDR},  m_state);
  endtask

  task automatic press(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b0, s);
  endtask

  task automatic release_key(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b1, s);
  endtask

  // Asynchronous reset between clock edges; outputs must clear with no clock.
  task automatic do_reset(input string tag);
    bus.KEY_ENTER = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_val({tag, "_ops"},   {24'h0, bus.OPS},   32'h00);
    chk_val({tag, "_valid"}, {31'h0, bus.VALID}, 32'h0);
    chk_val({tag, "_ledr"},  {30'h0, bus.LEDR},  32'h0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.KEY_ENTER = 1'b1;
    bus.SW        = 4'h0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk_val("rst_ops",   {24'h0, bus.OPS},   32'h00);
    chk_val("rst_valid", {31'h0, bus.VALID}, 32'h0);
    chk_val("rst_ledr",  {30'h0, bus.LEDR},  32'h0);
    rst_n = 1'b1;
    release_key(4'h0, 3);

    // Full entry A=3, B=5 with exact press latency.
    press(4'h3, 6);
    chk_val("a_early", {24'h0, bus.OPS}, 32'h00);
    press(4'h3, 1);
    chk_val("a_ops",  {24'h0, bus.OPS},  32'h03);
    chk_val("a_ledr", {30'h0, bus.LEDR}, 32'h1);
    release_key(4'h3, 8);
    press(4'h5, 6);
    chk_val("b_early", {31'h0, bus.VALID}, 32'h0);
    press(4'h5, 1);
    chk_val("b_ops",   {24'h0, bus.OPS},   32'h53);
    chk_val("b_valid", {31'h0, bus.VALID}, 32'h1);
    chk_val("b_ledr",  {30'h0, bus.LEDR},  32'h2);
    release_key(4'h5, 8);

    // Clear from DONE with SW=F: nothing captured.
    press(4'hF, 7);
    release_key(4'hF, 8);
    chk_val("clr_ops",   {24'h0, bus.OPS},   32'h00);
    chk_val("clr_valid", {31'h0, bus.VALID}, 32'h0);
    chk_val("clr_ledr",  {30'h0, bus.LEDR},  32'h0);

    // Bounce: 2-cycle toggles ignored, one advance once the key settles low.
    for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 1, 4'h7);
    chk_val("bnc_quiet", {30'h0, bus.LEDR}, 32'h0);
    press(4'h7, 6);
    chk_val("bnc_early", {24'h0, bus.OPS}, 32'h00);
    press(4'h7, 6);
    chk_val("bnc_ops",  {24'h0, bus.OPS},  32'h07);
    chk_val("bnc_ledr", {30'h0, bus.LEDR}, 32'h1);
    release_key(4'h7, 8);

    // Hold low for 100 cycles: exactly one capture.
    press(4'h9, 100);
    chk_val("hold_ops",  {24'h0, bus.OPS},  32'h97);
    chk_val("hold_ledr", {30'h0, bus.LEDR}, 32'h2);
    release_key(4'h9, 8);

    // 3-cycle glitch: no effect.
    press(4'h1, 3);
    release_key(4'h1, 12);
    chk_val("glitch_ops",  {24'h0, bus.OPS},  32'h97);
    chk_val("glitch_ledr", {30'h0, bus.LEDR}, 32'h2);
    press(4'h1, 7);
    release_key(4'h1, 8);

    // Timeout: capture A=A, then stay idle in WAIT_B.
    press(4'hA, 7);
    chk_val("to_a", {24'h0, bus.OPS}, 32'h0A);
    release_key(4'hA, 40);
`ifdef ENTRY_TIMEOUT_EN
    chk_val("to_ops",  {24'h0, bus.OPS},  32'h00);
    chk_val("to_ledr", {30'h0, bus.LEDR}, 32'h0);
`else
    chk_val("to_ops",  {24'h0, bus.OPS},  32'h0A);
    chk_val("to_ledr", {30'h0, bus.LEDR}, 32'h1);
`endif

    // Operand extremes 0 and F, then reset while in DONE.
    do_reset("rst1");
    release_key(4'h0, 3);
    press(4'h0, 7);
    release_key(4'h0, 8);
    press(4'hF, 7);
    chk_val("ext_ops", {24'h0, bus.OPS}, 32'hF0);
    release_key(4'hF, 8);
    press(4'h3, 7);
    release_key(4'h3, 8);
    press(4'h3, 7);
    release_key(4'h3, 8);
    press(4'h5, 7);
    release_key(4'h5, 4);
    chk_val("pre_rst_ops", {24'h0, bus.OPS}, 32'h53);
    do_reset("rst2");
    release_key(4'h5, 3);

    // Randomized runs of key levels and switch values.
    for (int r = 0; r < 300; r++) begin
      logic       k;
      logic [3:0] s;
      int         len;
      k   = 1'($urandom_range(0, 1));
      s   = 4'($urandom);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) s = 4'($urandom);
        step(k, s);
      end
      if (r == 150) do_reset("rst_rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
